// File: rtl/hsv_to_rgb_pipe.sv
// hsv_to_rgb_pipe
//   Streaming conversion of the unnormalised hue/chroma/value triple back to
//   8-bit R,G,B. The hue offset H is G-B for an R-max pixel, 2S+B-R for G-max
//   and 4S+R-G for B-max. Three register stages with a shared valid/ready
//   advance, so a stalled output freezes the whole pipe (bubbles are kept).
//
// Ports
//   clk, reset_n        : clock, synchronous active-low reset
//   in_valid / in_ready : input handshake (in_ready is combinational)
//   H_i, S_i, V_i       : signed hue offset, chroma (max-min), value (max)
//   sb_i / sb_o         : sideband word carried alongside each pixel
//   out_valid/out_ready : output handshake
//   R_o, G_o, B_o       : reconstructed colour
module hsv_to_rgb_pipe #(
  parameter int unsigned SB_W = 20
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [13:0]     H_i,
  input  logic        [7:0]      S_i,
  input  logic        [7:0]      V_i,
  input  logic        [SB_W-1:0] sb_i,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic        [7:0]      R_o,
  output logic        [7:0]      G_o,
  output logic        [7:0]      B_o,
  output logic        [SB_W-1:0] sb_o
);

  typedef enum logic [1:0] {SEC_GRAY, SEC_R, SEC_G, SEC_B} sector_e;

  logic en;

  // stage 1
  logic                   s1_vld_q;
  logic        [7:0]      s1_se_q, s1_mn_q, s1_v_q;
  logic signed [13:0]     s1_se2_q, s1_se4_q, s1_h_q;
  logic        [SB_W-1:0] s1_sb_q;
  logic        [7:0]      se_d, mn_d;

  // stage 2
  logic                   s2_vld_q, s2_neg_q;
  sector_e                s2_sec_q, sec_d;
  logic        [7:0]      s2_mag_q, s2_mn_q, s2_v_q, mag_d;
  logic        [SB_W-1:0] s2_sb_q;
  logic signed [15:0]     h_x, se_x, se2_x, se3_x, se4_x, off_raw, off_sat, mag_x;

  // stage 3
  logic                   s3_vld_q;
  logic        [7:0]      r_q, g_q, b_q, r_d, g_d, b_d, mid, up, dn;
  logic        [SB_W-1:0] sb_q;

  assign en        = !s3_vld_q || out_ready;
  assign in_ready  = en;
  assign out_valid = s3_vld_q;
  assign R_o       = r_q;
  assign G_o       = g_q;
  assign B_o       = b_q;
  assign sb_o      = sb_q;

  // Clamping S to V repairs S>V inputs so mn never underflows.
  always_comb begin
    se_d = (S_i < V_i) ? S_i : V_i;
    mn_d = V_i - se_d;
  end

  // Sector select on widened signed values; H-4*Se can leave the 14-bit range.
  always_comb begin
    h_x     = {{2{s1_h_q[13]}}, s1_h_q};
    se_x    = {8'b0, s1_se_q};
    se2_x   = {2'b0, s1_se2_q};
    se4_x   = {2'b0, s1_se4_q};
    se3_x   = se_x + se2_x;
    sec_d   = SEC_B;
    off_raw = h_x - se4_x;
    if (s1_se_q == 8'd0) begin
      sec_d   = SEC_GRAY;
      off_raw = '0;
    end else if (h_x <= se_x) begin
      sec_d   = SEC_R;
      off_raw = h_x;
    end else if (h_x <= se3_x) begin
      sec_d   = SEC_G;
      off_raw = h_x - se2_x;
    end
    // Saturation keeps the mid channel within [mn, V] for out-of-range H.
    if (off_raw > se_x)       off_sat = se_x;
    else if (off_raw < -se_x) off_sat = -se_x;
    else                      off_sat = off_raw;
    mag_x = off_sat[15] ? -off_sat : off_sat;
    mag_d = 8'(mag_x);
  end

  // Channel assignment; mid = mn + mag cannot exceed V since mag <= Se.
  always_comb begin
    mid = s2_mn_q + s2_mag_q;
    up  = s2_neg_q ? s2_mn_q : mid;
    dn  = s2_neg_q ? mid : s2_mn_q;
    r_d = s2_v_q;
    g_d = s2_v_q;
    b_d = s2_v_q;
    case (s2_sec_q)
      SEC_R:   begin g_d = up; b_d = dn; end
      SEC_G:   begin b_d = up; r_d = dn; end
      SEC_B:   begin r_d = up; g_d = dn; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_vld_q <= 1'b0;
      s1_se_q  <= '0;
      s1_mn_q  <= '0;
      s1_v_q   <= '0;
      s1_se2_q <= '0;
      s1_se4_q <= '0;
      s1_h_q   <= '0;
      s1_sb_q  <= '0;
      s2_vld_q <= 1'b0;
      s2_sec_q <= SEC_GRAY;
      s2_neg_q <= 1'b0;
      s2_mag_q <= '0;
      s2_mn_q  <= '0;
      s2_v_q   <= '0;
      s2_sb_q  <= '0;
      s3_vld_q <= 1'b0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
      sb_q     <= '0;
    end else if (en) begin
      s1_vld_q <= in_valid;
      s1_se_q  <= se_d;
      s1_mn_q  <= mn_d;
      s1_v_q   <= V_i;
      s1_se2_q <= {5'b0, se_d, 1'b0};
      s1_se4_q <= {4'b0, se_d, 2'b0};
      s1_h_q   <= H_i;
      s1_sb_q  <= sb_i;
      s2_vld_q <= s1_vld_q;
      s2_sec_q <= sec_d;
      s2_neg_q <= off_sat[15];
      s2_mag_q <= mag_d;
      s2_mn_q  <= s1_mn_q;
      s2_v_q   <= s1_v_q;
      s2_sb_q  <= s1_sb_q;
      s3_vld_q <= s2_vld_q;
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
      sb_q     <= s2_sb_q;
    end
  end

endmodule

// File: tb/tb_hsv_to_rgb_pipe.sv
// tb_hsv_to_rgb_pipe
//   Directed vectors, reset, backpressure and randomized round-trip /
//   out-of-range checks for hsv_to_rgb_pipe against a behavioural model.
module tb_hsv_to_rgb_pipe;
  localparam int unsigned SB_W = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset_n, in_valid, in_ready, out_valid, out_ready;
  logic signed [13:0]     H_i;
  logic        [7:0]      S_i, V_i, R_o, G_o, B_o;
  logic        [SB_W-1:0] sb_i, sb_o;

  hsv_to_rgb_pipe #(.SB_W(SB_W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .H_i(H_i), .S_i(S_i), .V_i(V_i), .sb_i(sb_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .R_o(R_o), .G_o(G_o), .B_o(B_o), .sb_o(sb_o)
  );

  typedef struct packed {
    logic [23:0]     rgb;
    logic [SB_W-1:0] sb;
  } pix_t;

  pix_t exp_q[$];
  pix_t cur_exp;
  int   checks = 0;
  int   failures = 0;
  int   popped = 0;
  bit   stalled = 1'b0;
  bit   accepted = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Forward colour-space equations of the RGB->HSV front end.
  task automatic rgb2hsv(input int r, input int g, input int b,
                         output int h, output int s, output int v);
    int mx, mn;
    mx = imax(r, imax(g, b));
    mn = imin(r, imin(g, b));
    s = mx - mn;
    v = mx;
    if (r >= g && r >= b) h = g - b;
    else if (g >= b)      h = 2 * s + b - r;
    else                  h = 4 * s + r - g;
  endtask

  // Hexcone inverse: locate the dominant channel from H, clamp the offset,
  // then the other two channels are min and min+|offset|.
  function automatic logic [23:0] hsv2rgb(input int h, input int s, input int v);
    int se, mn, off, mid, hi_c, lo_c, r, g, b;
    se = imin(s, v);
    mn = v - se;
    if (se == 0) return {8'(v), 8'(v), 8'(v)};
    if (h <= se)          off = h;
    else if (h <= 3 * se) off = h - 2 * se;
    else                  off = h - 4 * se;
    off  = imax(-se, imin(se, off));
    mid  = mn + ((off < 0) ? -off : off);
    hi_c = (off >= 0) ? mid : mn;
    lo_c = (off >= 0) ? mn : mid;
    if (h <= se)          begin r = v;    g = hi_c; b = lo_c; end
    else if (h <= 3 * se) begin g = v;    b = hi_c; r = lo_c; end
    else                  begin b = v;    r = hi_c; g = lo_c; end
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  task automatic drive(input int h, input int s, input int v,
                       input logic [SB_W-1:0] sb, input logic [23:0] want);
    H_i = 14'(h);
    S_i = 8'(s);
    V_i = 8'(v);
    sb_i = sb;
    cur_exp.rgb = want;
    cur_exp.sb  = sb;
  endtask

  // One clock: sample at negedge+1, score, then advance to the next negedge.
  task automatic step();
    #1;
    if (stalled) chk("stall_hold_valid", out_valid, 1'b1);
    if (out_valid) begin
      chk("in_ready_busy", in_ready, out_ready);
      if (exp_q.size() == 0) chk("spurious_out_valid", out_valid, 1'b0);
      else begin
        chk("rgb", {R_o, G_o, B_o}, exp_q[0].rgb);
        chk("sb", sb_o, exp_q[0].sb);
        if (out_ready) begin
          void'(exp_q.pop_front());
          popped++;
        end
      end
    end else begin
      chk("in_ready_idle", in_ready, 1'b1);
    end
    stalled  = out_valid && !out_ready;
    accepted = in_valid && in_ready;
    if (accepted) exp_q.push_back(cur_exp);
    @(negedge clk);
  endtask

  // Single pixel through an empty pipe with out_ready held high.
  task automatic directed(input string tag, input int h, input int s, input int v,
                          input logic [23:0] want);
    logic [SB_W-1:0] sb;
    sb = SB_W'($urandom);
    drive(h, s, v, sb, want);
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_lat1"}, out_valid, 1'b0);
    @(negedge clk);
    chk({tag, "_lat2"}, out_valid, 1'b0);
    @(negedge clk);
    chk({tag, "_lat3"}, out_valid, 1'b1);
    chk({tag, "_rgb"}, {R_o, G_o, B_o}, want);
    chk({tag, "_sb"}, sb_o, sb);
    @(negedge clk);
    chk({tag, "_gone"}, out_valid, 1'b0);
  endtask

  task automatic gen_pixel(input bit roundtrip);
    int r, g, b, h, s, v;
    if (roundtrip) begin
      r = ($urandom_range(3) == 0) ? 0 : (($urandom_range(3) == 0) ? 255 : int'($urandom_range(255)));
      g = ($urandom_range(3) == 0) ? 0 : (($urandom_range(3) == 0) ? 255 : int'($urandom_range(255)));
      b = ($urandom_range(3) == 0) ? 0 : (($urandom_range(3) == 0) ? 255 : int'($urandom_range(255)));
      rgb2hsv(r, g, b, h, s, v);
      drive(h, s, v, SB_W'($urandom), {8'(r), 8'(g), 8'(b)});
    end else begin
      h = int'($urandom_range(2100)) - 600;
      s = int'($urandom_range(255));
      v = int'($urandom_range(255));
      drive(h, s, v, SB_W'($urandom), hsv2rgb(h, s, v));
    end
  endtask

  task automatic run_random(input int n, input bit roundtrip);
    bit have;
    have = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (!have) begin
        gen_pixel(roundtrip);
        have = 1'b1;
      end
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      step();
      if (accepted) have = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
    chk(roundtrip ? "rt_drain" : "model_drain", exp_q.size(), 0);
  endtask

  initial begin
    logic [23:0] bp_rgb [8];
    int sent, h, s, v;

    // Reset with in_valid asserted: nothing may emerge.
    reset_n = 1'b0;
    out_ready = 1'b1;
    drive(-50, 150, 200, '0, 24'h000000);
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_valid", out_valid, 1'b0);
    chk("reset_rgb", {R_o, G_o, B_o}, 24'h000000);
    chk("reset_sb", sb_o, '0);
    reset_n = 1'b1;

    // Directed sectors, gray, black, clamped and invalid inputs.
    directed("secR",    -50, 150, 200, {8'd200, 8'd50,  8'd100});
    directed("secG",    480, 230, 240, {8'd10,  8'd240, 8'd30});
    directed("secB",    790, 190, 250, {8'd90,  8'd60,  8'd250});
    directed("gray",      0,   0, 128, {8'd128, 8'd128, 8'd128});
    directed("black",     0,   0,   0, {8'd0,   8'd0,   8'd0});
    directed("clampHi", 1000,  10, 100, {8'd100, 8'd90,  8'd100});
    directed("sgtv",    -50, 200,  50, {8'd50,  8'd0,   8'd50});
    directed("clampLo", -400,  20,  60, {8'd60,  8'd40,  8'd60});
    directed("bndR",     100, 100, 180, {8'd180, 8'd180, 8'd80});
    directed("bndG",     300, 100, 180, {8'd80,  8'd180, 8'd180});
    directed("v0",       500, 200,   0, {8'd0,   8'd0,   8'd0});

    // Backpressure: 8 pixels, output stalled on cycles 4..7.
    for (int i = 0; i < 8; i++) bp_rgb[i] = 24'($urandom);
    sent = 0;
    popped = 0;
    for (int cyc = 0; cyc < 40 && (sent < 8 || exp_q.size() > 0); cyc++) begin
      if (sent < 8) begin
        rgb2hsv(int'(bp_rgb[sent][23:16]), int'(bp_rgb[sent][15:8]), int'(bp_rgb[sent][7:0]), h, s, v);
        drive(h, s, v, SB_W'(sent + 16'h0A00), bp_rgb[sent]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = !(cyc >= 4 && cyc <= 7);
      step();
      if (accepted) sent++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_count", popped, 8);
    chk("bp_left", exp_q.size(), 0);

    // Reset mid-stream discards in-flight pixels.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      gen_pixel(1'b1);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    chk("midreset_valid", out_valid, 1'b0);
    chk("midreset_rgb", {R_o, G_o, B_o}, 24'h000000);
    reset_n = 1'b1;
    exp_q.delete();
    stalled = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("postreset_idle", out_valid, 1'b0);
    end

    // Randomized loop-back and out-of-range hue checks with random handshake.
    run_random(3000, 1'b1);
    run_random(2000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
